// File: rtl/riscv_pkg.sv
// Shared types and constants for the multicycle RV32I controller.
// alu_dec maps funct3/funct7[5] onto the ALU operation encoding.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MULDIV, S_MEM_ADDR, S_MEM_READ, S_MEM_WRITE,
        S_WB_MEM, S_WB_ALU, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;
    localparam logic [2:0] ALU_SLTU  = 3'd6;
    localparam logic [2:0] ALU_SHIFT = 3'd7;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // funct7[5] only selects SUB for register-register ops; SRAI is told apart by shift_op.
    function automatic logic [2:0] alu_dec(input logic [2:0] funct3, input logic f7b5,
                                           input logic is_r);
        logic [2:0] op;
        case (funct3)
            3'd0:       op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'd1, 3'd5: op = ALU_SHIFT;
            3'd2:       op = ALU_SLT;
            3'd3:       op = ALU_SLTU;
            3'd4:       op = ALU_XOR;
            3'd6:       op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mem_timeout.sv
// Counts cycles a memory request waits without ready; flags the last allowed wait cycle.
// TIMEOUT_CYCLES == 0 removes the counter entirely.
module mem_timeout #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = clk ^ rst_n ^ clear_i ^ enable_i;
            assign expire_o      = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
            localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] cnt_q, cnt_d;

            // Expire on the wait cycle whose edge would make the count reach the limit.
            assign expire_o = enable_i && (cnt_q == LAST);

            always_comb begin
                cnt_d = cnt_q;
                if (clear_i)
                    cnt_d = '0;
                else if (enable_i && cnt_q != MAX)
                    cnt_d = cnt_q + 1'b1;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end
        end
    endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback over a ready/valid
// memory port, optional multicycle MUL/DIV handshake, illegal-op and bus-timeout traps.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter bit ENABLE_M       = 1'b0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       branch_taken,
    input  logic       mem_ready,
    input  logic       md_done,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       addr_sel,
    output logic [2:0] imm_sel,
    output logic [1:0] src_a_sel,
    output logic [1:0] src_b_sel,
    output logic [2:0] alu_func,
    output logic [1:0] shift_op,
    output logic       mem_req,
    output logic       mem_write,
    output logic [2:0] mem_size,
    output logic       reg_write,
    output logic [1:0] regd_sel,
    output logic       md_start,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_t     state_q, state_nxt, state_d;
    logic [1:0] cause_q, cause_nxt, cause_d;
    logic       md_busy_q;
    logic       tmo_expire;

    mem_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (mem_req && mem_ready),
        .enable_i (mem_req && !mem_ready),
        .expire_o (tmo_expire)
    );

    assign shift_op   = {funct7[5], funct3[2]};
    assign mem_size   = (state_q == S_FETCH) ? SIZE_WORD : funct3;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;

    // Strobes are gated by rst_n so they drop the moment reset asserts.
    always_comb begin
        state_nxt = state_q;
        cause_nxt = cause_q;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        addr_sel  = 1'b0;
        imm_sel   = IMM_I;
        src_a_sel = 2'd0;
        src_b_sel = 2'd0;
        alu_func  = ALU_ADD;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        regd_sel  = 2'd0;
        md_start  = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    src_a_sel = 2'd1;
                    src_b_sel = 2'd2;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    src_a_sel = 2'd2;
                    src_b_sel = 2'd1;
                    imm_sel   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                    case (opcode)
                        OP_R: begin
                            if (funct7 != F7_MULDIV) state_nxt = S_EXEC_R;
                            else if (ENABLE_M)       state_nxt = S_MULDIV;
                            else begin
                                state_nxt = S_TRAP;
                                cause_nxt = CAUSE_ILLEGAL;
                            end
                        end
                        OP_I:              state_nxt = S_EXEC_I;
                        OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
                        OP_BRANCH:         state_nxt = S_BRANCH;
                        OP_JAL:            state_nxt = S_JAL;
                        OP_JALR:           state_nxt = S_JALR;
                        OP_LUI:            state_nxt = S_LUI;
                        OP_AUIPC:          state_nxt = S_AUIPC;
                        default: begin
                            state_nxt = S_TRAP;
                            cause_nxt = CAUSE_ILLEGAL;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    alu_func  = alu_dec(funct3, funct7[5], 1'b1);
                    state_nxt = S_WB_ALU;
                end
                S_EXEC_I: begin
                    src_b_sel = 2'd1;
                    alu_func  = alu_dec(funct3, funct7[5], 1'b0);
                    state_nxt = S_WB_ALU;
                end
                S_MULDIV: begin
                    md_start = !md_busy_q;
                    if (md_done) state_nxt = S_WB_ALU;
                end
                S_MEM_ADDR: begin
                    src_b_sel = 2'd1;
                    imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                    state_nxt = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    if (mem_ready) state_nxt = S_WB_MEM;
                end
                S_MEM_WRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    addr_sel  = 1'b1;
                    if (mem_ready) state_nxt = S_FETCH;
                end
                S_WB_MEM: begin
                    reg_write = 1'b1;
                    regd_sel  = 2'd1;
                    state_nxt = S_FETCH;
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_BRANCH: begin
                    case (funct3[2:1])
                        2'b10:   alu_func = ALU_SLT;
                        2'b11:   alu_func = ALU_SLTU;
                        default: alu_func = ALU_SUB;
                    endcase
                    pc_write  = branch_taken;
                    pc_src    = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_JAL: begin
                    reg_write = 1'b1;
                    regd_sel  = 2'd3;
                    pc_write  = 1'b1;
                    pc_src    = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_JALR: begin
                    src_b_sel = 2'd1;
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                    regd_sel  = 2'd3;
                    state_nxt = S_FETCH;
                end
                S_LUI: begin
                    imm_sel   = IMM_U;
                    reg_write = 1'b1;
                    regd_sel  = 2'd2;
                    state_nxt = S_FETCH;
                end
                S_AUIPC: begin
                    src_a_sel = 2'd2;
                    src_b_sel = 2'd1;
                    imm_sel   = IMM_U;
                    state_nxt = S_WB_ALU;
                end
                default: ;
            endcase
        end
    end

    // Timeout overrides in a separate process so mem_req does not loop back into its own block.
    always_comb begin
        state_d = tmo_expire ? S_TRAP : state_nxt;
        cause_d = tmo_expire ? CAUSE_TIMEOUT : cause_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cause_q   <= CAUSE_NONE;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            md_busy_q <= (state_q == S_MULDIV);
        end
    end

endmodule
